// File: rtl/fetch_exec_ctrl.sv
// Fetch/execute sequencer for the nibble processor: fetches 8-bit instructions over a
// req/ready handshake, resolves conditional jumps from C/Z and emits one-cycle datapath strobes.
module fetch_exec_ctrl #(
  parameter int unsigned PC_W = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            mem_ready,
  input  logic [7:0]      instr,
  input  logic            C,
  input  logic            Z,
  output logic            mem_req,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      operand,
  output logic [1:0]      alu_op,
  output logic            acc_en,
  output logic            flags_en,
  output logic            ram_we,
  output logic            ram_oe,
  output logic            in_en,
  output logic            out_en,
  output logic            halted
);

  typedef enum logic [1:0] {StFetch, StAddr, StExec, StHalt} state_e;

  localparam logic [1:0] AluAdd  = 2'b00;
  localparam logic [1:0] AluSub  = 2'b01;
  localparam logic [1:0] AluNand = 2'b10;
  localparam logic [1:0] AluPass = 2'b11;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            armed_q;
  logic            taken;
  logic [PC_W-1:0] pc_inc;
  logic [11:0]     jump_tgt;

  assign pc_inc   = pc_q + PC_W'(1);
  assign jump_tgt = {ir_q[3:0], instr};
  assign pc       = pc_q;
  assign operand  = ir_q[3:0];

  // Holds mem_req low for the first cycle after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= 8'h00;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    taken    = 1'b0;
    mem_req  = 1'b0;
    halted   = 1'b0;
    alu_op   = AluPass;
    acc_en   = 1'b0;
    flags_en = 1'b0;
    ram_we   = 1'b0;
    ram_oe   = 1'b0;
    in_en    = 1'b0;
    out_en   = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_req = armed_q;
        if (armed_q && mem_ready) begin
          ir_d    = instr;
          pc_d    = pc_inc;
          state_d = (instr[7:4] >= 4'h1 && instr[7:4] <= 4'h5) ? StAddr : StExec;
        end
      end
      StAddr: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          case (ir_q[7:4])
            4'h1:    taken = C;
            4'h2:    taken = !C;
            4'h3:    taken = Z;
            4'h4:    taken = !Z;
            4'h5:    taken = 1'b1;
            default: taken = 1'b0;
          endcase
          pc_d    = taken ? PC_W'(jump_tgt) : pc_inc;
          state_d = StFetch;
        end
      end
      StExec: begin
        case (ir_q[7:4])
          4'h6: begin alu_op = AluSub; flags_en = 1'b1; end
          4'h7: begin acc_en = 1'b1; flags_en = 1'b1; end
          4'h8: begin in_en = 1'b1; acc_en = 1'b1; flags_en = 1'b1; end
          4'h9: out_en = 1'b1;
          4'hA: begin alu_op = AluAdd; acc_en = 1'b1; flags_en = 1'b1; end
          4'hB: begin alu_op = AluSub; acc_en = 1'b1; flags_en = 1'b1; end
          4'hC: begin alu_op = AluNand; acc_en = 1'b1; flags_en = 1'b1; end
          4'hD: ram_we = 1'b1;
          4'hE: begin ram_oe = 1'b1; acc_en = 1'b1; flags_en = 1'b1; end
          default: ;
        endcase
        state_d = (ir_q[7:4] == 4'hF) ? StHalt : StFetch;
      end
      StHalt: begin
        halted = 1'b1;
        if (run) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Directed bench for fetch_exec_ctrl: a behavioural program memory answers mem_req and each
// response is compared against hand-computed pc/strobe values.
module tb_fetch_exec_ctrl;

  logic        clk;
  logic        reset;
  logic        run;
  logic        mem_ready;
  logic [7:0]  instr;
  logic        C;
  logic        Z;
  logic        mem_req;
  logic [11:0] pc;
  logic [3:0]  operand;
  logic [1:0]  alu_op;
  logic        acc_en, flags_en, ram_we, ram_oe, in_en, out_en, halted;

  logic [7:0]  mem [0:4095];
  logic        ready;
  logic [7:0]  strb;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_exec_ctrl #(.PC_W(12)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .mem_ready(mem_ready),
    .instr    (instr),
    .C        (C),
    .Z        (Z),
    .mem_req  (mem_req),
    .pc       (pc),
    .operand  (operand),
    .alu_op   (alu_op),
    .acc_en   (acc_en),
    .flags_en (flags_en),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .in_en    (in_en),
    .out_en   (out_en),
    .halted   (halted)
  );

  assign mem_ready = ready;
  assign instr     = mem[pc];
  // {alu_op, acc_en, flags_en, ram_we, ram_oe, in_en, out_en}
  assign strb      = {alu_op, acc_en, flags_en, ram_we, ram_oe, in_en, out_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  endtask

  // Release at a falling edge, then step past the first rising edge.
  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] dec_prog [0:9];
  logic [7:0] dec_exp  [0:9];

  initial begin
    reset = 1'b0;
    run   = 1'b0;
    ready = 1'b1;
    C     = 1'b0;
    Z     = 1'b0;
    clear_mem();

    // 1: reset state, then LIT 1
    mem[0] = 8'h71;
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_strobes", strb, 8'b1100_0000);
    chk("rst_operand", operand, 0);
    release_reset();
    chk("t1_first_req", mem_req, 1);
    chk("t1_pc_before", pc, 0);
    step();
    chk("t1_pc_after", pc, 1);
    chk("t1_exec_strobes", strb, 8'b1111_0000);
    chk("t1_operand", operand, 1);
    chk("t1_exec_req", mem_req, 0);
    step();
    chk("t1_fetch_strobes", strb, 8'b1100_0000);
    chk("t1_fetch_req", mem_req, 1);

    // 2: wait states
    reset = 1'b0;
    clear_mem();
    ready = 1'b0;
    release_reset();
    chk("t2_req_c1", mem_req, 1);
    chk("t2_pc_c1", pc, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_req_wait", mem_req, 1);
      chk("t2_pc_wait", pc, 0);
    end
    ready = 1'b1;
    step();
    chk("t2_pc_ready", pc, 1);
    chk("t2_exec_req", mem_req, 0);

    // 3: JZ taken / not taken, JC taken
    for (int k = 0; k < 3; k++) begin
      reset = 1'b0;
      clear_mem();
      mem[0] = (k == 2) ? 8'h15 : 8'h3A;
      mem[1] = (k == 2) ? 8'h67 : 8'hBC;
      Z = (k == 0);
      C = (k == 2);
      release_reset();
      step();
      chk("t3_addr_pc", pc, 1);
      chk("t3_addr_req", mem_req, 1);
      chk("t3_addr_strobes", strb, 8'b1100_0000);
      step();
      chk("t3_target", pc, (k == 0) ? 12'hABC : (k == 1) ? 12'h002 : 12'h567);
      chk("t3_fetch_req", mem_req, 1);
    end
    C = 1'b0;
    Z = 1'b0;

    // 4: HLT then run
    reset = 1'b0;
    clear_mem();
    mem[0] = 8'hF0;
    release_reset();
    step();
    chk("t4_exec_strobes", strb, 8'b1100_0000);
    step();
    for (int i = 0; i < 10; i++) begin
      chk("t4_halted", halted, 1);
      chk("t4_req", mem_req, 0);
      chk("t4_pc", pc, 1);
      step();
    end
    @(negedge clk);
    run = 1'b1;
    step();
    run = 1'b0;
    chk("t4_resume_halted", halted, 0);
    chk("t4_resume_req", mem_req, 1);
    chk("t4_resume_pc", pc, 1);

    // 5: pc wrap
    reset = 1'b0;
    clear_mem();
    mem[0] = 8'h5F;
    mem[1] = 8'hFF;
    release_reset();
    step();
    step();
    chk("t5_pc_fff", pc, 12'hFFF);
    step();
    chk("t5_pc_wrap", pc, 12'h000);

    // 6: async reset mid-ADDR
    reset = 1'b0;
    clear_mem();
    mem[0] = 8'h5A;
    mem[1] = 8'hBC;
    release_reset();
    step();
    chk("t6_addr_req", mem_req, 1);
    chk("t6_addr_pc", pc, 1);
    #1;
    ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("t6_async_req", mem_req, 0);
    chk("t6_async_pc", pc, 0);
    chk("t6_async_strobes", strb, 8'b1100_0000);
    mem[0] = 8'h71;
    ready = 1'b1;
    release_reset();
    chk("t6_restart_req", mem_req, 1);
    chk("t6_restart_pc", pc, 0);
    step();
    chk("t6_restart_fetch", pc, 1);
    chk("t6_restart_strobes", strb, 8'b1111_0000);

    // Decode table over every non-jump opcode except HLT
    dec_prog = '{8'h61, 8'h72, 8'h83, 8'h94, 8'hA5, 8'hB6, 8'hC7, 8'hD8, 8'hE9, 8'h0A};
    dec_exp  = '{8'b0101_0000, 8'b1111_0000, 8'b1111_0010, 8'b1100_0001, 8'b0011_0000,
                 8'b0111_0000, 8'b1011_0000, 8'b1100_1000, 8'b1111_0100, 8'b1100_0000};
    reset = 1'b0;
    clear_mem();
    for (int i = 0; i < 10; i++) mem[i] = dec_prog[i];
    release_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("dec_%0h_strobes", dec_prog[i][7:4]), strb, dec_exp[i]);
      chk($sformatf("dec_%0h_operand", dec_prog[i][7:4]), operand, 32'(dec_prog[i][3:0]));
      step();
      chk($sformatf("dec_%0h_idle", dec_prog[i][7:4]), strb, 8'b1100_0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
